// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader constants, state encodings and the FSM state type.
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_0000
`endif
`ifndef LOADER_SYNC_BYTE
`define LOADER_SYNC_BYTE 8'hA5
`define LD_IDLE  3'd0
`define LD_LEN   3'd1
`define LD_DATA  3'd2
`define LD_CSUM  3'd3
`define LD_DONE  3'd4
`define LD_ERROR 3'd5
`endif

package imem_loader_pkg;
    localparam int unsigned LOADER_MAX_BYTES = 1001;
    typedef enum logic [2:0] {
        IDLE  = `LD_IDLE,
        LEN   = `LD_LEN,
        DATA  = `LD_DATA,
        CSUM  = `LD_CSUM,
        DONE  = `LD_DONE,
        ERROR = `LD_ERROR
    } ld_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte receive stream plus the byte-wide instruction-memory load port.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        PC_to_mem_enable;
    logic [7:0]  PC_to_mem_data;
    logic [31:0] PC_to_mem_address;
    modport master (input rx_valid, rx_data,
                    output rx_ready, PC_to_mem_enable, PC_to_mem_data, PC_to_mem_address);
    modport slave  (output rx_valid, rx_data,
                    input rx_ready, PC_to_mem_enable, PC_to_mem_data, PC_to_mem_address);
endinterface

// File: rtl/imem_loader_checksum.sv
// loader_checksum: mod-256 running sum of payload bytes, checked against a two's-complement trailer.
`ifdef IMEM_LOADER_CHECKSUM_EN
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       ok
);
    logic [7:0] sum;
    always_ff @(posedge clk)
        if (rst || clr) sum <= '0;
        else if (add) sum <= sum + din;
    assign ok = din == 8'(~sum + 8'd1);
endmodule
`endif

// File: rtl/imem_loader.sv
// imem_loader: parses SYNC/len/payload frames into INS_MEMORY writes and holds the CPU until a good load.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte to each frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_BYTES = LOADER_MAX_BYTES,
    parameter logic [7:0]  SYNC_BYTE = `LOADER_SYNC_BYTE
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_error
);
    ld_state_t   state, state_n;
    logic [31:0] len, len_n, idx, waddr;
    logic [1:0]  cnt;
    logic [7:0]  wdata;
    logic        rdy, we, go, start, take, last, fin;

    assign go    = bus.rx_valid && rdy;
    assign start = go && bus.rx_data == SYNC_BYTE && (state == IDLE || state == DONE || state == ERROR);
    assign take  = go && state == DATA;
    assign len_n = {len[23:0], bus.rx_data};
    assign last  = idx == len - 32'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ld_state_t TAIL = CSUM;
    logic csum_ok;
    loader_checksum u_csum (
        .clk(SYS_clk), .rst(SYS_reset), .clr(start), .add(take), .din(bus.rx_data), .ok(csum_ok)
    );
    // done rises on the edge that accepts a matching checksum
    assign fin = state_n == DONE;
`else
    localparam ld_state_t TAIL = DONE;
    // done rises one edge after DONE is entered, i.e. while the last write is presented
    assign fin = state == DONE;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: state_n = start ? LEN : state;
            LEN:  state_n = go && cnt == 2'd3 ?
                            (len_n > MAX_BYTES ? ERROR : len_n == 32'd0 ? TAIL : DATA) : LEN;
            DATA: state_n = go && last ? TAIL : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: state_n = go ? (csum_ok ? DONE : ERROR) : CSUM;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            cnt        <= '0;
            rdy        <= 1'b0;
            we         <= 1'b0;
            wdata      <= '0;
            waddr      <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state <= state_n;
            rdy   <= 1'b1;
            we    <= take;
            if (take) begin
                wdata <= bus.rx_data;
                waddr <= `INS_START_ADDRESS + idx;
                idx   <= idx + 32'd1;
            end
            if (go && state == LEN) begin
                len <= len_n;
                cnt <= cnt + 2'd1;
            end
            if (state_n == ERROR) load_error <= 1'b1;
            if (fin) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
            // a new SYNC outranks everything else above
            if (start) begin
                len        <= '0;
                idx        <= '0;
                cnt        <= '0;
                cpu_hold   <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end
        end
    end

    assign bus.rx_ready          = rdy;
    assign bus.PC_to_mem_enable  = we;
    assign bus.PC_to_mem_data    = wdata;
    assign bus.PC_to_mem_address = waddr;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random framed streams against a frame-level model; a monitor scores memory writes.
module tb_imem_loader;
    localparam int unsigned MAX = 1001;
    localparam logic [7:0] SYNC = 8'hA5;

    logic SYS_clk = 1'b0;
    logic SYS_reset = 1'b1;
    logic cpu_hold, load_done, load_error;

    imem_loader_if bus();

    imem_loader dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .bus(bus),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 SYS_clk = ~SYS_clk;

    int cyc = 0;
    always @(posedge SYS_clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge SYS_clk) begin : monitor
        wr_t e;
        if (bus.PC_to_mem_enable === 1'b1) begin
            if (exq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got addr %h data %h, expected no write", bus.PC_to_mem_address, bus.PC_to_mem_data);
            end else begin
                e = exq.pop_front();
                chk("wr_addr", bus.PC_to_mem_address, e.a);
                chk("wr_data", {24'd0, bus.PC_to_mem_data}, {24'd0, e.d});
                chk("wr_cycle", cyc, e.t);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge SYS_clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    // accepted on the following rising edge; a payload byte is expected on the bus one cycle later
    task automatic send(input logic [7:0] b, input bit payload, input int off);
        int n = 0;
        do begin
            @(negedge SYS_clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = b;
            n++;
        end while (bus.rx_ready !== 1'b1 && n < 50);
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got %b, expected 1 within 50 cycles", bus.rx_ready);
        end else if (payload)
            exq.push_back('{cyc + 1, `INS_START_ADDRESS + 32'(off), b});
    endtask

    // gap > 0: random idle cycles up to gap between payload bytes; gap < 0: exactly -gap idle cycles
    task automatic frame(input logic [31:0] len, input logic [7:0] pl[$], input int gap, input bit badcs);
        logic [31:0] lv;
        int sm;
        bit ok;
        lv = len;
        sm = 0;
        ok = len <= MAX;
        send(SYNC, 0, 0);
        for (int i = 0; i < 4; i++) send(lv[8*(3-i) +: 8], 0, 0);
        if (ok)
            for (int i = 0; i < pl.size(); i++) begin
                send(pl[i], 1, i);
                sm = (sm + int'(pl[i])) % 256;
                if (i < pl.size() - 1 && gap != 0) idle(gap < 0 ? -gap : $urandom_range(0, gap));
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (ok) begin
            send(badcs ? 8'((257 - sm) % 256) : 8'((256 - sm) % 256), 0, 0);
            ok = !badcs;
        end
`endif
        @(negedge SYS_clk);
        bus.rx_valid = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (ok) chk("done_timing", {31'd0, load_done}, 32'd0);
`endif
        @(negedge SYS_clk);
        chk("load_done", {31'd0, load_done}, {31'd0, ok});
        chk("load_error", {31'd0, load_error}, {31'd0, !ok});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
        chk("writes_drained", exq.size(), 32'd0);
    endtask

    task automatic check_reset;
        chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("rst_enable", {31'd0, bus.PC_to_mem_enable}, 32'd0);
        chk("rst_data", {24'd0, bus.PC_to_mem_data}, 32'd0);
        chk("rst_address", bus.PC_to_mem_address, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_error", {31'd0, load_error}, 32'd0);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] none[$];
        logic [7:0] g;
        logic [31:0] len;
        bit bad;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge SYS_clk);
        check_reset();
        SYS_reset = 1'b0;

        send(8'h00, 0, 0);
        send(8'h11, 0, 0);
        idle(2);
        chk("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("idle_load_done", {31'd0, load_done}, 32'd0);

        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        frame(32'd4, pl, 0, 0);

        frame(32'h0000_0400, none, 0, 0);
        pl = '{8'hDE, 8'hAD, 8'hA5, 8'hEF};
        frame(32'd4, pl, 0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pl = '{8'h01, 8'h02, 8'h03};
        frame(32'd3, pl, 0, 0);
        frame(32'd3, pl, 0, 1);
`endif

        // reset right after the 2nd of 4 payload bytes; that byte's write is still presented
        send(SYNC, 0, 0);
        send(8'h00, 0, 0);
        send(8'h00, 0, 0);
        send(8'h00, 0, 0);
        send(8'h04, 0, 0);
        send(8'h21, 1, 0);
        send(8'h22, 1, 1);
        @(negedge SYS_clk);
        SYS_reset = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge SYS_clk);
        check_reset();
        SYS_reset = 1'b0;
        pl = '{8'h44, 8'h55, 8'h66, 8'h77};
        frame(32'd4, pl, 0, 0);

        pl = '{8'h10, 8'h20, 8'h30, 8'h40};
        frame(32'd4, pl, -1, 0);

        pl = {};
        repeat (MAX) pl.push_back(8'($urandom));
        frame(MAX, pl, 0, 0);
        frame(MAX + 1, none, 0, 0);
        frame(32'd0, none, 0, 0);

        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                send(g == SYNC ? 8'h00 : g, 0, 0);
            end
            pl = {};
            if ($urandom_range(0, 7) == 0)
                len = MAX + 1 + $urandom_range(0, 100000);
            else begin
                len = $urandom_range(0, 24);
                repeat (len) pl.push_back(8'($urandom));
            end
            bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad = $urandom_range(0, 3) == 0;
`endif
            frame(len, pl, $urandom_range(0, 2), bad);
        end

        idle(4);
        chk("final_queue_empty", exq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 2 ms");
        $fatal(1);
    end
endmodule
